key_debounce_quad: RTL and testbench



---
 rtl/key_pkg.sv | 19 +
 rtl/key_filter_1ch.sv | 140 ++++++++++++++
 rtl/key_debounce_quad.sv | 54 +++++
 tb/tb_key_debounce_quad.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encoding and timing defaults for the key debouncer
// Contents: per-key FSM state enum, default timing constants, and key count.
// The optional auto-repeat feature is enabled by defining KEY_REPEAT_EN.
package key_pkg;

  typedef enum logic [1:0] {
    KS_IDLE       = 2'd0,
    KS_PRESS_FILT = 2'd1,
    KS_DOWN       = 2'd2,
    KS_REL_FILT   = 2'd3
  } key_st_e;

  localparam int NUM_KEYS              = 4;
  localparam int DEF_DEBOUNCE_CYCLES   = 1_000_000;
  localparam int DEF_CNT_W             = 20;
  localparam int DEF_REPEAT_DELAY      = 25_000_000;
  localparam int DEF_REPEAT_PERIOD     = 5_000_000;

endpackage

// File: rtl/key_filter_1ch.sv
// rtl/key_filter_1ch.sv - synchroniser, debounce FSM and edge pulse for one key
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   key_raw     raw button, active-low (0 = pressed)
//   key_flag    one-cycle pulse per accepted press (plus repeats with KEY_REPEAT_EN)
//   key_state   debounced level, 1 = held
// Macro KEY_REPEAT_EN adds auto-repeat pulses while the key is held.
module key_filter_1ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
`ifdef KEY_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_flag,
  output logic key_state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             key_s;
  key_st_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             flag_q, flag_d;

  // Sync flops reset to 1 so a reset looks like "released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], key_raw};
  end

  assign key_s   = ~sync_q[1];
  // Saturating increment: the filter counter must never wrap.
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_first_q, rep_first_d;
  logic             rep_hit;

  // First repeat uses the long delay, later ones the short period.
  assign rep_hit = (rep_cnt_q == (rep_first_q ? REP_FIRST : REP_NEXT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= KS_IDLE;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
    end
  end

  // cnt_d defaults to zero so every state change restarts the filter.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    flag_d  = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
`endif
    case (state_q)
      KS_IDLE: begin
        if (key_s) state_d = KS_PRESS_FILT;
      end
      KS_PRESS_FILT: begin
        if (!key_s) begin
          state_d = KS_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = KS_DOWN;
          flag_d  = 1'b1;
`ifdef KEY_REPEAT_EN
          rep_cnt_d   = '0;
          rep_first_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      KS_DOWN: begin
        if (!key_s) state_d = KS_REL_FILT;
`ifdef KEY_REPEAT_EN
        if (rep_hit) begin
          flag_d      = 1'b1;
          rep_cnt_d   = '0;
          rep_first_d = 1'b0;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
`endif
      end
      KS_REL_FILT: begin
        // Repeat counter is held here so a bounce back to DOWN resumes it.
        if (key_s) begin
          state_d = KS_DOWN;
        end else if (cnt_q == CNT_LAST) begin
          state_d = KS_IDLE;
`ifdef KEY_REPEAT_EN
          rep_cnt_d   = '0;
          rep_first_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = KS_IDLE;
    endcase
  end

  assign key_flag  = flag_q;
  assign key_state = (state_q == KS_DOWN) || (state_q == KS_REL_FILT);

endmodule

// File: rtl/key_debounce_quad.sv
// rtl/key_debounce_quad.sv - four independent debounced push-buttons with press pulses
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   key_in[3:0]          raw buttons, active-low; bit0..3 -> key_flag1..4
//   key_flag1..4         one-cycle pulse per accepted press
//   key_state[3:0]       debounced level per key, 1 = held
// Macro KEY_REPEAT_EN adds auto-repeat pulses while a key is held.
module key_debounce_quad
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
`ifdef KEY_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic                key_flag1,
  output logic                key_flag2,
  output logic                key_flag3,
  output logic                key_flag4,
  output logic [NUM_KEYS-1:0] key_state
);

  logic [NUM_KEYS-1:0] flags;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_filter_1ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
`ifdef KEY_REPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_filter (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_raw  (key_in[k]),
      .key_flag (flags[k]),
      .key_state(key_state[k])
    );
  end

  assign key_flag1 = flags[0];
  assign key_flag2 = flags[1];
  assign key_flag3 = flags[2];
  assign key_flag4 = flags[3];

endmodule

// File: tb/tb_key_debounce_quad.sv
// tb/tb_key_debounce_quad.sv - self-checking bench for key_debounce_quad
module tb_key_debounce_quad;

  localparam int D   = 8;
  localparam int RD  = 40;
  localparam int RP  = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_in = 4'hF;
  logic       key_flag1, key_flag2, key_flag3, key_flag4;
  logic [3:0] key_state;
  logic [3:0] flags_act;

  int checks = 0;
  int failures = 0;

  assign flags_act = {key_flag4, key_flag3, key_flag2, key_flag1};

  always #5 clk = ~clk;

  key_debounce_quad #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (20)
`ifdef KEY_REPEAT_EN
    ,
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .key_flag1(key_flag1),
    .key_flag2(key_flag2),
    .key_flag3(key_flag3),
    .key_flag4(key_flag4),
    .key_state(key_state)
  );

  // Reference model: a press/release is accepted once the synchronised
  // (two-sample delayed) level has differed from the accepted level for
  // D+1 consecutive samples.
  bit         m_d1[4], m_d2[4], m_down[4];
  int         m_run[4];
  logic [3:0] m_flag, m_state;
`ifdef KEY_REPEAT_EN
  int         m_rep[4];
  bit         m_first[4];
`endif

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      m_d1[k] = 0; m_d2[k] = 0; m_down[k] = 0; m_run[k] = 0;
`ifdef KEY_REPEAT_EN
      m_rep[k] = 0; m_first[k] = 1;
`endif
    end
    m_flag = 4'h0;
    m_state = 4'h0;
  endfunction

  function automatic void model_edge(input logic [3:0] kin);
    for (int k = 0; k < 4; k++) begin
      bit s;
      s = m_d2[k];
      m_d2[k] = m_d1[k];
      m_d1[k] = ~kin[k];
      m_flag[k] = 1'b0;
      if (!m_down[k]) begin
        m_run[k] = s ? m_run[k] + 1 : 0;
        if (m_run[k] == D + 1) begin
          m_down[k] = 1; m_run[k] = 0; m_flag[k] = 1'b1;
`ifdef KEY_REPEAT_EN
          m_rep[k] = 0; m_first[k] = 1;
`endif
        end
      end else if (m_run[k] == 0) begin
`ifdef KEY_REPEAT_EN
        // Edges spent held: fire at RD after entry, then every RP.
        if (m_rep[k] == (m_first[k] ? RD - 1 : RP - 1)) begin
          m_flag[k] = 1'b1; m_rep[k] = 0; m_first[k] = 0;
        end else begin
          m_rep[k]++;
        end
`endif
        if (!s) m_run[k] = 1;
      end else begin
        if (s) begin
          m_run[k] = 0;
        end else begin
          m_run[k]++;
          if (m_run[k] == D + 1) begin
            m_down[k] = 0; m_run[k] = 0;
`ifdef KEY_REPEAT_EN
            m_rep[k] = 0; m_first[k] = 1;
`endif
          end
        end
      end
      m_state[k] = m_down[k];
    end
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive key_in, let the edge happen, sample 1 time unit later.
  task automatic step(input logic [3:0] kin);
    key_in = kin;
    @(posedge clk);
    #1;
    model_edge(kin);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'hF);
  endtask

  typedef struct {
    logic [3:0] kin;
    logic [3:0] exp_flag;
    logic [3:0] exp_state;
  } vec_t;

  vec_t tbl[32];
  int   rep_pulses[$];

  initial begin
    // Clean press on key 0 held 20 cycles, then clean release.
    for (int i = 0; i < 32; i++) begin
      tbl[i].kin       = (i < 20) ? 4'b1110 : 4'b1111;
      tbl[i].exp_flag  = (i == 10) ? 4'b0001 : 4'b0000;
      tbl[i].exp_state = (i >= 10 && i < 30) ? 4'b0001 : 4'b0000;
    end
`ifdef KEY_REPEAT_EN
    rep_pulses = '{10, 50, 60, 70, 80, 90, 100};
`else
    rep_pulses = '{10};
`endif

    model_reset();
    key_in = 4'hF;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", flags_act, 4'h0);
    chk("reset_state", key_state, 4'h0);
    rst_n = 1'b1;
    idle(4);

    for (int i = 0; i < 32; i++) begin
      step(tbl[i].kin);
      chk($sformatf("table_flag[%0d]", i), flags_act, tbl[i].exp_flag);
      chk($sformatf("table_state[%0d]", i), key_state, tbl[i].exp_state);
    end
    idle(4);

    // Key 1 bouncing every 3 cycles never gets accepted.
    for (int i = 0; i < 42; i++) begin
      step((i < 30 && ((i / 3) % 2 == 0)) ? 4'b1101 : 4'b1111);
      chk("bounce_flag", flags_act, 4'h0);
      chk("bounce_state", key_state, 4'h0);
    end

    // Key 2: accept, ride out 5-cycle release glitches, then clean release.
    for (int i = 0; i < 12; i++) begin
      step(4'b1011);
      if (i == 10) chk("rel_press_flag", flags_act, 4'b0100);
    end
    chk("rel_pressed_state", key_state, 4'b0100);
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 10; i++) begin
        step(i < 5 ? 4'b1111 : 4'b1011);
        chk("rel_glitch_flag", flags_act, 4'h0);
        chk("rel_glitch_state", key_state, 4'b0100);
      end
    end
    for (int i = 0; i < 12; i++) begin
      step(4'b1111);
      chk("rel_clean_flag", flags_act, 4'h0);
      if (i == 9)  chk("rel_before_accept", key_state, 4'b0100);
      if (i == 10) chk("rel_accept_state", key_state, 4'b0000);
    end

    // Keys 0 and 1 pressed together pulse together.
    for (int i = 0; i < 12; i++) begin
      step(4'b1100);
      chk("simul_flag", flags_act, (i == 10) ? 4'b0011 : 4'b0000);
    end
    chk("simul_state", key_state, 4'b0011);
    idle(12);
    chk("simul_released", key_state, 4'h0);

    // Long hold on key 0: single pulse, or repeats when enabled.
    for (int i = 0; i <= 100; i++) begin
      step(4'b1110);
      chk($sformatf("hold_flag[%0d]", i), flags_act,
          (i inside {rep_pulses}) ? 4'b0001 : 4'b0000);
    end
    idle(12);

    // Reset in the middle of key 3's press filter (count 5).
    for (int i = 0; i < 8; i++) step(4'b0111);
    rst_n = 1'b0;
    #2;
    chk("midrst_flags", flags_act, 4'h0);
    chk("midrst_state", key_state, 4'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(4'b0111);
      chk("postrst_flag", flags_act, (i == 10) ? 4'b1000 : 4'b0000);
      chk("postrst_state", key_state, (i >= 10) ? 4'b1000 : 4'b0000);
    end
    idle(12);

    // Randomised independent keys against the reference model.
    begin
      logic [3:0] kin;
      kin = 4'hF;
      for (int i = 0; i < 3000; i++) begin
        for (int k = 0; k < 4; k++)
          if ($urandom_range(0, 5) == 0) kin[k] = ~kin[k];
        step(kin);
        chk("rand_flag", flags_act, m_flag);
        chk("rand_state", key_state, m_state);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
